dtv1_macc_ctrl: RTL and testbench
=================================

// Module: dtv1_macc_ctrl
// PURPOSE
//  Sequencer for the DTV1 MAC array (NUM_PE FP mul/add lanes, 1-cycle registered mul/add stages, tail accumulator).
//  Accepts one command per operation and drives the operand-buffer reads, all lane enables and all mux selects.
//  Two modes:
//  - MAC: per-lane dot products over K steps.
//  - DOT: the MAC phase, then a cross-lane prefix-sum reduction folded into the tail accumulator.
// PARAMETERS
//  NUM_PE   16  lanes in the MAC array
//  K_BW     10  width of step count / read index
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous reset, active-high
//  cmd_valid        in   1        command offered
//  cmd_ready        out  1        high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_mode         in   1        0 = MAC, 1 = DOT
//  cmd_k_len        in   K_BW     number of accumulate steps K
//  cmd_use_bias     in   1        first add step takes din_buf (sel 01) instead of 0 (sel 00)
//  cmd_mul_src      in   1        mul_mux_sel value for the whole op (0 = weight, 1 = buf)
//  cmd_acc_mode     in   2        acc_mux_sel used in the DOT ACC cycle (00 clr, 01 buf, 10 accumulate)
//  cmd_lane_mask    in   NUM_PE   lanes enabled for mul/add in the MAC phase (bit 0 = PE0)
//  rd_en            out  1        operand-buffer read strobe; data is expected 1 cycle later
//  rd_idx           out  K_BW     step index k of the current read
//  en_mul           out  NUM_PE   mul register enables
//  en_add           out  NUM_PE   add register enables
//  en_acc           out  1        accumulator register enable
//  mul_mux_sel      out  1        to array
//  add_mux0_sel     out  1        0 = mul_out_r1, 1 = neighbour add_out_r1[pe-1]
//  add_mux1_sel     out  2        00 zero, 01 din_buf, 10 own add_out_r1
//  acc_mux_sel      out  2        to array
//  res_valid        out  1        array outputs hold the final result; held until res_ready
//  res_ready        in   1        consumer has taken the result
//  busy             out  1        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all enables, rd_en and res_valid = 0; all selects = 0; rd_idx = 0; cmd_ready = 1.
//  Command fields are latched on accept; the inputs are don't-care afterwards.
//  States: IDLE -> ISSUE -> DRAIN -> (DOT: REDUCE -> ACC) -> DONE -> IDLE.
//  Timing, accept at cycle 0:
//  - ISSUE: cycles 1..K; rd_en = 1, rd_idx = 0..K-1.
//  - en_mul = lane_mask at cycles 2..K+1 (rd_en delayed 1).
//  - en_add = lane_mask at cycles 3..K+2 (rd_en delayed 2); add_mux0_sel = 0.
//  - add_mux1_sel = (use_bias ? 01 : 00) on the step-0 add, 10 on every later step.
//  - mul_mux_sel = mul_src whenever en_mul is high, 0 otherwise.
//  - DRAIN: cycles K+1..K+2, waits for the pipeline to empty.
//  - MAC mode: DONE from cycle K+3; res_valid = 1; dout_acc[0..NUM_PE-1] is final.
//  - DOT mode: REDUCE for NUM_PE-1 cycles, step s = 1..NUM_PE-1.
//    en_add = one-hot bit s; add_mux0_sel = 1; add_mux1_sel = 10.
//    Result: add_out_r1[NUM_PE-1] = sum over all lanes.
//  - DOT mode: ACC for 1 cycle; en_acc = 1; acc_mux_sel = acc_mode. Then DONE; dout_acc[NUM_PE] is final.
//  DONE: res_valid held; leave to IDLE the cycle after res_valid & res_ready. No enables are asserted in DONE.
//  K = 0: no rd/mul/add activity; DRAIN is skipped.
//  - MAC: DONE at cycle 1.
//  - DOT: REDUCE + ACC still run on the existing array contents.
//  Masked-off lanes never get en_mul/en_add in ISSUE. REDUCE ignores lane_mask; masked lanes must hold the clear value the software expects.
//  cmd_valid is ignored outside IDLE (cmd_ready = 0); there are no queued commands.
//  rst mid-op: next cycle IDLE; the delay line is flushed to 0; no further enables. Array contents are untouched.
//  Selects outside the cycles above are driven 0, so the array does not toggle when idle.
// STRUCTURE
//  Package dtv1_macc_ctrl_pkg:
//  - state enum: IDLE, ISSUE, DRAIN, REDUCE, ACC, DONE
//  - mux select localparams: SEL_ZERO, SEL_BUF, SEL_FB, SEL_CHAIN
//  - mode enum: MAC, DOT
//  Sub-module dtv1_macc_ctrl_dly:
//  - 2-stage shift register of {valid, first, lane_mask}
//  - produces the en_mul/en_add timing and the step-0 flag
//  Top: FSM, k/s counters, output mux.
// TESTING
//  1 MAC, K=4, mask=all, bias=0:
//    rd_en cycles 1-4 (idx 0..3); en_mul 2-5; en_add 3-6; add_mux1 00@3 then 10@4-6; res_valid@7.
//  2 MAC, K=1, bias=1, mask=16'h00FF:
//    en_mul/en_add = 16'h00FF only; add_mux1 = 01@3; res_valid@4; all-ones products -> dout_acc[0..7] = 1+bias.
//  3 DOT, K=2, NUM_PE=16, acc_mode=10, run twice:
//    en_add one-hot bits 1..15 over cycles 5..19; en_acc@20; second run acc = 2x first.
//  4 Handshake: hold res_ready=0 for 5 cycles in DONE.
//    res_valid stays 1, no enables, cmd_valid ignored; ready pulse -> IDLE next cycle; new cmd accepted.
//  5 rst asserted at cycle 3 of a K=8 MAC:
//    next cycle all outputs at reset values; cmd_ready = 1; new K=1 cmd runs with correct timing.
//  6 K=0: MAC -> res_valid@1 with no enables; DOT -> REDUCE+ACC only, no rd_en.

Source files
------------

// File: rtl/dtv1_macc_ctrl_pkg.sv
// Shared types and select encodings for the DTV1 MAC array sequencer.
package dtv1_macc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        REDUCE,
        ACC,
        DONE
    } state_e;

    typedef enum logic {
        MAC = 1'b0,
        DOT = 1'b1
    } mode_e;

    // add_mux1 / acc_mux encodings
    localparam logic [1:0] SEL_ZERO  = 2'b00;
    localparam logic [1:0] SEL_BUF   = 2'b01;
    localparam logic [1:0] SEL_FB    = 2'b10;
    // add_mux0: take neighbour add_out_r1[pe-1] instead of own mul_out_r1
    localparam logic       SEL_CHAIN = 1'b1;

    // read -> mul -> add, one register each
    localparam int DLY_STAGES = 2;

    // step-0 add seeds the lane from the bias buffer or from zero
    function automatic logic [1:0] first_add_sel(input logic use_bias);
        return use_bias ? SEL_BUF : SEL_ZERO;
    endfunction

endpackage

// File: rtl/dtv1_macc_ctrl_dly.sv
// Delay line that turns the read strobe into mul/add lane enables.
module dtv1_macc_ctrl_dly
    import dtv1_macc_ctrl_pkg::*;
#(
    parameter int NUM_PE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic              in_first,
    input  logic [NUM_PE-1:0] in_mask,
    output logic              mul_vld,
    output logic [NUM_PE-1:0] en_mul,
    output logic              add_vld,
    output logic              add_first,
    output logic [NUM_PE-1:0] en_add
);

    typedef struct packed {
        logic              first;
        logic [NUM_PE-1:0] mask;
    } stg_t;

    logic [DLY_STAGES:1] vld_pipe;
    stg_t [DLY_STAGES:1] dat_pipe;
    stg_t                in_stg;

    assign in_stg = {in_first, in_mask};

    // Shift valid and payload together; reset flushes so no stale enables leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DLY_STAGES-1:1], in_vld};
            dat_pipe <= {dat_pipe[DLY_STAGES-1:1], in_stg};
        end
    end

    assign mul_vld   = vld_pipe[1];
    assign en_mul    = vld_pipe[1] ? dat_pipe[1].mask : '0;
    assign add_vld   = vld_pipe[DLY_STAGES];
    assign add_first = vld_pipe[DLY_STAGES] & dat_pipe[DLY_STAGES].first;
    assign en_add    = vld_pipe[DLY_STAGES] ? dat_pipe[DLY_STAGES].mask : '0;

endmodule

// File: rtl/dtv1_macc_ctrl.sv
// DTV1 MAC array sequencer: per-lane MAC over K steps, optional cross-lane reduce into the tail accumulator.
module dtv1_macc_ctrl
    import dtv1_macc_ctrl_pkg::*;
#(
    parameter int NUM_PE = 16,
    parameter int K_BW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [K_BW-1:0]   cmd_k_len,
    input  logic              cmd_use_bias,
    input  logic              cmd_mul_src,
    input  logic [1:0]        cmd_acc_mode,
    input  logic [NUM_PE-1:0] cmd_lane_mask,
    output logic              rd_en,
    output logic [K_BW-1:0]   rd_idx,
    output logic [NUM_PE-1:0] en_mul,
    output logic [NUM_PE-1:0] en_add,
    output logic              en_acc,
    output logic              mul_mux_sel,
    output logic              add_mux0_sel,
    output logic [1:0]        add_mux1_sel,
    output logic [1:0]        acc_mux_sel,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    localparam int S_W = $clog2(NUM_PE);

    state_e            state, state_nxt;
    mode_e             mode_q;
    logic [K_BW-1:0]   k_len_q;
    logic              bias_q;
    logic              src_q;
    logic [1:0]        accm_q;
    logic [NUM_PE-1:0] mask_q;
    logic [K_BW-1:0]   k_cnt;
    logic [S_W-1:0]    s_cnt;
    logic              accept;
    logic              issue;
    logic              mul_vld, add_vld, add_first;
    logic [NUM_PE-1:0] dly_en_mul, dly_en_add;

    assign issue  = (state == ISSUE);
    assign accept = cmd_valid & (state == IDLE);

    dtv1_macc_ctrl_dly #(.NUM_PE(NUM_PE)) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (issue),
        .in_first  (k_cnt == '0),
        .in_mask   (mask_q),
        .mul_vld   (mul_vld),
        .en_mul    (dly_en_mul),
        .add_vld   (add_vld),
        .add_first (add_first),
        .en_add    (dly_en_add)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture the command on accept so the inputs are free afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MAC;
            k_len_q <= '0;
            bias_q  <= 1'b0;
            src_q   <= 1'b0;
            accm_q  <= '0;
            mask_q  <= '0;
        end else if (accept) begin
            mode_q  <= mode_e'(cmd_mode);
            k_len_q <= cmd_k_len;
            bias_q  <= cmd_use_bias;
            src_q   <= cmd_mul_src;
            accm_q  <= cmd_acc_mode;
            mask_q  <= cmd_lane_mask;
        end
    end

    // k counts read steps in ISSUE; s walks the reduce chain starting at lane 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt <= '0;
            s_cnt <= S_W'(1);
        end else begin
            k_cnt <= issue ? k_cnt + K_BW'(1) : '0;
            s_cnt <= (state == REDUCE) ? s_cnt + S_W'(1) : S_W'(1);
        end
    end

    // Next-state logic; K=0 skips ISSUE/DRAIN entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (cmd_valid) begin
                        if (cmd_k_len == '0)
                            state_nxt = (mode_e'(cmd_mode) == DOT) ? REDUCE : DONE;
                        else
                            state_nxt = ISSUE;
                    end
            ISSUE:  if (k_cnt == k_len_q - K_BW'(1)) state_nxt = DRAIN;
            // Leave once the last product has moved into the add stage.
            DRAIN:  if (!mul_vld) state_nxt = (mode_q == DOT) ? REDUCE : DONE;
            REDUCE: if (s_cnt == S_W'(NUM_PE-1)) state_nxt = ACC;
            ACC:    state_nxt = DONE;
            DONE:   if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux; every select rests at 0 outside its active cycles.
    always_comb begin
        cmd_ready    = (state == IDLE);
        busy         = (state != IDLE);
        res_valid    = (state == DONE);
        rd_en        = issue;
        rd_idx       = issue ? k_cnt : '0;
        en_mul       = dly_en_mul;
        mul_mux_sel  = mul_vld & src_q;
        en_add       = dly_en_add;
        add_mux0_sel = 1'b0;
        add_mux1_sel = SEL_ZERO;
        en_acc       = 1'b0;
        acc_mux_sel  = SEL_ZERO;
        if (add_vld)
            add_mux1_sel = add_first ? first_add_sel(bias_q) : SEL_FB;
        if (state == REDUCE) begin
            en_add       = NUM_PE'(1) << s_cnt;
            add_mux0_sel = SEL_CHAIN;
            add_mux1_sel = SEL_FB;
        end
        if (state == ACC) begin
            en_acc      = 1'b1;
            acc_mux_sel = accm_q;
        end
    end

endmodule

// File: tb/tb_dtv1_macc_ctrl.sv
// Scoreboard bench: stimulus queues the expected per-cycle control vector, monitor compares at negedge.
module tb_dtv1_macc_ctrl;

    localparam int NUM_PE = 16;
    localparam int K_BW   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_mode, cmd_use_bias, cmd_mul_src;
    logic [K_BW-1:0]   cmd_k_len;
    logic [1:0]        cmd_acc_mode;
    logic [NUM_PE-1:0] cmd_lane_mask;
    logic              rd_en;
    logic [K_BW-1:0]   rd_idx;
    logic [NUM_PE-1:0] en_mul, en_add;
    logic              en_acc, mul_mux_sel, add_mux0_sel;
    logic [1:0]        add_mux1_sel, acc_mux_sel;
    logic              res_valid, res_ready, busy;

    typedef struct packed {
        logic              cmd_ready;
        logic              rd_en;
        logic [K_BW-1:0]   rd_idx;
        logic [NUM_PE-1:0] en_mul;
        logic [NUM_PE-1:0] en_add;
        logic              en_acc;
        logic              mul_mux_sel;
        logic              add_mux0_sel;
        logic [1:0]        add_mux1_sel;
        logic [1:0]        acc_mux_sel;
        logic              res_valid;
        logic              busy;
    } obs_t;

    typedef struct packed {
        int   tid;
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t exp_q[$];
    obs_t obs;
    int   checks   = 0;
    int   failures = 0;

    assign obs = {cmd_ready, rd_en, rd_idx, en_mul, en_add, en_acc, mul_mux_sel,
                  add_mux0_sel, add_mux1_sel, acc_mux_sel, res_valid, busy};

    dtv1_macc_ctrl #(.NUM_PE(NUM_PE), .K_BW(K_BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_k_len     (cmd_k_len),
        .cmd_use_bias  (cmd_use_bias),
        .cmd_mul_src   (cmd_mul_src),
        .cmd_acc_mode  (cmd_acc_mode),
        .cmd_lane_mask (cmd_lane_mask),
        .rd_en         (rd_en),
        .rd_idx        (rd_idx),
        .en_mul        (en_mul),
        .en_add        (en_add),
        .en_acc        (en_acc),
        .mul_mux_sel   (mul_mux_sel),
        .add_mux0_sel  (add_mux0_sel),
        .add_mux1_sel  (add_mux1_sel),
        .acc_mux_sel   (acc_mux_sel),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Monitor: one expected vector per cycle while the scoreboard holds entries.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.o) begin
                failures++;
                $display("FAIL t%0d_c%0d got=%h exp=%h diff=%h", e.tid, e.cyc, obs, e.o, obs ^ e.o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic obs_t idle_vec();
        obs_t o;
        o = '0;
        o.cmd_ready = 1'b1;
        return o;
    endfunction

    task automatic push_exp(input int tid, input int cyc, input obs_t o);
        exp_t e;
        e.tid = tid;
        e.cyc = cyc;
        e.o   = o;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1 of cycle 0. Expected trace follows the cycle timeline of the op.
    task automatic run_cmd(input int tid, input bit mode, input int k, input bit bias,
                           input bit src, input logic [1:0] accm, input logic [NUM_PE-1:0] mask,
                           input int hold, input bit poke, input int rst_at);
        int   post, done_s, last;
        obs_t o;
        post   = (k > 0) ? k + 3 : 1;
        done_s = mode ? post + NUM_PE : post;
        last   = (rst_at >= 0) ? rst_at + 1 : done_s + hold + 1;
        for (int n = 0; n <= last; n++) begin
            if (n == 0 || n == last) begin
                o = idle_vec();
            end else begin
                o = '0;
                o.busy = 1'b1;
                if (n <= k) begin
                    o.rd_en  = 1'b1;
                    o.rd_idx = K_BW'(n - 1);
                end
                if (n >= 2 && n <= k + 1) begin
                    o.en_mul      = mask;
                    o.mul_mux_sel = src;
                end
                if (n >= 3 && n <= k + 2) begin
                    o.en_add       = mask;
                    o.add_mux1_sel = (n == 3) ? (bias ? 2'b01 : 2'b00) : 2'b10;
                end
                if (mode && n >= post && n < post + NUM_PE - 1) begin
                    o.en_add       = 16'd1 << (n - post + 1);
                    o.add_mux0_sel = 1'b1;
                    o.add_mux1_sel = 2'b10;
                end
                if (mode && n == post + NUM_PE - 1) begin
                    o.en_acc      = 1'b1;
                    o.acc_mux_sel = accm;
                end
                if (n >= done_s) o.res_valid = 1'b1;
            end
            push_exp(tid, n, o);
        end
        cmd_valid     = 1'b1;
        cmd_mode      = mode;
        cmd_k_len     = K_BW'(k);
        cmd_use_bias  = bias;
        cmd_mul_src   = src;
        cmd_acc_mode  = accm;
        cmd_lane_mask = mask;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                // scramble the fields: the op must run from the latched copy
                cmd_valid     = 1'b0;
                cmd_mode      = ~mode;
                cmd_k_len     = ~K_BW'(k);
                cmd_use_bias  = ~bias;
                cmd_mul_src   = ~src;
                cmd_acc_mode  = ~accm;
                cmd_lane_mask = ~mask;
            end
            rst       = (rst_at >= 0 && n == rst_at);
            res_ready = (rst_at < 0 && n == done_s + hold);
            if (poke) cmd_valid = (n >= done_s && n < done_s + hold);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_mode      = 1'b0;
        cmd_k_len     = '0;
        cmd_use_bias  = 1'b0;
        cmd_mul_src   = 1'b0;
        cmd_acc_mode  = '0;
        cmd_lane_mask = '0;
        res_ready     = 1'b0;
        @(posedge clk); #1;
        push_exp(0, 0, idle_vec());
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(0, 1, idle_vec());
        @(posedge clk); #1;

        // MAC K=4, all lanes, no bias
        run_cmd(1, 1'b0, 4, 1'b0, 1'b1, 2'b00, 16'hFFFF, 0, 1'b0, -1);
        // MAC K=1, bias, lower lanes only
        run_cmd(2, 1'b0, 1, 1'b1, 1'b0, 2'b00, 16'h00FF, 0, 1'b0, -1);
        // DOT K=2 twice; mask must not affect the reduce chain
        run_cmd(3, 1'b1, 2, 1'b0, 1'b1, 2'b10, 16'h0F0F, 0, 1'b0, -1);
        run_cmd(4, 1'b1, 2, 1'b1, 1'b0, 2'b10, 16'hFFFF, 0, 1'b0, -1);
        // DONE held 5 cycles with cmd_valid poked, then a fresh command
        run_cmd(5, 1'b0, 3, 1'b0, 1'b1, 2'b00, 16'hA5A5, 5, 1'b1, -1);
        run_cmd(6, 1'b0, 2, 1'b1, 1'b1, 2'b00, 16'h8001, 0, 1'b0, -1);
        // reset in cycle 3 of a K=8 MAC, then a K=1 op
        run_cmd(7, 1'b0, 8, 1'b0, 1'b1, 2'b00, 16'hFFFF, 0, 1'b0, 3);
        run_cmd(8, 1'b0, 1, 1'b0, 1'b1, 2'b00, 16'h1234, 0, 1'b0, -1);
        // K=0 in both modes
        run_cmd(9, 1'b0, 0, 1'b1, 1'b1, 2'b00, 16'hFFFF, 0, 1'b0, -1);
        run_cmd(10, 1'b1, 0, 1'b0, 1'b1, 2'b01, 16'hFFFF, 2, 1'b0, -1);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
